// File: rtl/match_game_pkg.sv
// rtl/match_game_pkg.sv - shared states, LFSR seed base, tap table and seed helper for match_game_ctrl
package match_game_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_PLAY = 2'b01,
    ST_WIN  = 2'b10,
    ST_LOSE = 2'b11
  } game_state_t;

  localparam logic [7:0] LFSR_SEED_BASE = 8'h35;

  // Maximal-length tap masks; bit n-1 set for tap n, widths 4..16
  function automatic logic [15:0] lfsr_taps(input int width);
    case (width)
      4:       return 16'h000C;
      5:       return 16'h0014;
      6:       return 16'h0030;
      7:       return 16'h0060;
      8:       return 16'h00B8;
      9:       return 16'h0110;
      10:      return 16'h0240;
      11:      return 16'h0500;
      12:      return 16'h0829;
      13:      return 16'h100D;
      14:      return 16'h2015;
      15:      return 16'h6000;
      16:      return 16'hD008;
      default: return 16'h00B8;
    endcase
  endfunction

  // Per-channel seed; zero and the XNOR lockup value (all ones) are replaced by 1
  function automatic logic [15:0] lfsr_seed(input int idx, input int width);
    logic [15:0] mask;
    logic [15:0] s;
    mask = 16'hFFFF >> (16 - width);
    s    = 16'((idx + 1) * int'(LFSR_SEED_BASE)) & mask;
    if (s == 16'd0 || s == mask) s = 16'd1;
    return s;
  endfunction

endpackage

// File: rtl/match_game_ctrl_if.sv
// rtl/match_game_ctrl_if.sv - board-side bundle of match_game_ctrl; score only with MATCH_GAME_SCORE_EN
interface match_game_ctrl_if #(
  parameter int NUM_CH   = 3,
  parameter int SYM_BITS = 2
);

  logic                         start;
  logic [NUM_CH*SYM_BITS-1:0]   guess;
  logic [NUM_CH*SYM_BITS-1:0]   target;
  logic [NUM_CH-1:0]            match_vec;
  logic [3:0]                   secs_ones;
  logic [3:0]                   secs_tens;
  logic [1:0]                   state;
  logic                         win;
  logic                         lose;
  logic                         flash;
`ifdef MATCH_GAME_SCORE_EN
  logic [7:0]                   score;

  modport master (output start, guess,
                  input  target, match_vec, secs_ones, secs_tens, state, win, lose, flash, score);
  modport slave  (input  start, guess,
                  output target, match_vec, secs_ones, secs_tens, state, win, lose, flash, score);
`else
  modport master (output start, guess,
                  input  target, match_vec, secs_ones, secs_tens, state, win, lose, flash);
  modport slave  (input  start, guess,
                  output target, match_vec, secs_ones, secs_tens, state, win, lose, flash);
`endif

endinterface

// File: rtl/match_lfsr.sv
// rtl/match_lfsr.sv - free-running Fibonacci XNOR LFSR reduced to a symbol below NUM_SYMS
module match_lfsr
  import match_game_pkg::*;
#(
  parameter int                LFSR_W   = 8,
  parameter logic [LFSR_W-1:0] SEED     = 1,
  parameter int                SYM_BITS = 2,
  parameter int                NUM_SYMS = 3
) (
  input  logic                clk,
  input  logic                clear_b,
  output logic [SYM_BITS-1:0] sym
);

  localparam logic [15:0]       TAPS16 = lfsr_taps(LFSR_W);
  localparam logic [LFSR_W-1:0] TAPS   = TAPS16[LFSR_W-1:0];

  logic [LFSR_W-1:0]   lfsr;
  logic                fb;
  logic [SYM_BITS-1:0] raw;

  assign fb = ~^(lfsr & TAPS);

  // Shift every cycle regardless of game state
  always_ff @(posedge clk or negedge clear_b) begin
    if (!clear_b) lfsr <= SEED;
    else          lfsr <= {lfsr[LFSR_W-2:0], fb};
  end

  // NUM_SYMS > 2^(SYM_BITS-1), so a single conditional subtract folds raw into range
  assign raw = lfsr[SYM_BITS-1:0];
  assign sym = ({1'b0, raw} >= (SYM_BITS+1)'(NUM_SYMS)) ? raw - SYM_BITS'(NUM_SYMS) : raw;

endmodule

// File: rtl/match_game_ctrl.sv
// rtl/match_game_ctrl.sv - round controller: targets, BCD seconds timer, WIN/LOSE FSM, flash; score via MATCH_GAME_SCORE_EN
module match_game_ctrl
  import match_game_pkg::*;
#(
  parameter int NUM_CH      = 3,
  parameter int SYM_BITS    = 2,
  parameter int NUM_SYMS    = 3,
  parameter int LFSR_W      = 8,
  parameter int CLK_HZ      = 50_000_000,
  parameter int ROUND_SECS  = 60,
  parameter int FLASH_TICKS = 1
) (
  input logic              clk,
  input logic              clear_b,
  match_game_ctrl_if.slave bus
);

  localparam int               PRE_W      = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PRE_W-1:0] PRE_RELOAD = PRE_W'(CLK_HZ - 1);
  localparam int               FL_W       = (FLASH_TICKS > 1) ? $clog2(FLASH_TICKS) : 1;
  localparam logic [FL_W-1:0]  FL_LAST    = FL_W'(FLASH_TICKS - 1);
  localparam logic [3:0]       RS_TENS    = 4'(ROUND_SECS / 10);
  localparam logic [3:0]       RS_ONES    = 4'(ROUND_SECS % 10);

  game_state_t                st;
  logic                       start_q;
  logic                       start_edge;
  logic [PRE_W-1:0]           presc;
  logic                       tick;
  logic [NUM_CH*SYM_BITS-1:0] sym_all;
  logic [NUM_CH*SYM_BITS-1:0] target_r;
  logic [NUM_CH-1:0]          match_vec;
  logic                       all_match;
  logic [3:0]                 secs_ones_r;
  logic [3:0]                 secs_tens_r;
  logic [3:0]                 ones_nxt;
  logic [3:0]                 tens_nxt;
  logic                       timeout;
  logic [FL_W-1:0]            flash_cnt;
  logic                       flash_r;
  logic                       win_r;
  logic                       lose_r;
`ifdef MATCH_GAME_SCORE_EN
  logic [7:0]                 score_r;
`endif

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    localparam logic [15:0] SEED16 = lfsr_seed(i, LFSR_W);

    match_lfsr #(
      .LFSR_W  (LFSR_W),
      .SEED    (SEED16[LFSR_W-1:0]),
      .SYM_BITS(SYM_BITS),
      .NUM_SYMS(NUM_SYMS)
    ) u_lfsr (
      .clk    (clk),
      .clear_b(clear_b),
      .sym    (sym_all[i*SYM_BITS +: SYM_BITS])
    );

    assign match_vec[i] = (st != ST_IDLE) &&
                          (bus.guess[i*SYM_BITS +: SYM_BITS] == target_r[i*SYM_BITS +: SYM_BITS]);
  end

  assign all_match  = &match_vec;
  assign start_edge = bus.start & ~start_q;
  assign tick       = (st != ST_IDLE) && (presc == '0);

  // BCD increment of the elapsed seconds and the timeout it would cause
  always_comb begin
    ones_nxt = secs_ones_r + 4'd1;
    tens_nxt = secs_tens_r;
    if (secs_ones_r == 4'd9) begin
      ones_nxt = 4'd0;
      tens_nxt = secs_tens_r + 4'd1;
    end
    timeout = (tens_nxt == RS_TENS) && (ones_nxt == RS_ONES);
  end

  // Previous start level for rising-edge detection
  always_ff @(posedge clk or negedge clear_b) begin
    if (!clear_b) start_q <= 1'b0;
    else          start_q <= bus.start;
  end

  // One-second prescaler, running only while a round is active or finished
  always_ff @(posedge clk or negedge clear_b) begin
    if (!clear_b)              presc <= PRE_RELOAD;
    else if (start_edge)       presc <= PRE_RELOAD;
    else if (st != ST_IDLE)    presc <= (presc == '0) ? PRE_RELOAD : presc - PRE_W'(1);
  end

  // Round FSM with registered targets, timer, flash and status outputs
  always_ff @(posedge clk or negedge clear_b) begin
    if (!clear_b) begin
      st          <= ST_IDLE;
      target_r    <= '0;
      secs_ones_r <= 4'd0;
      secs_tens_r <= 4'd0;
      flash_r     <= 1'b0;
      flash_cnt   <= '0;
      win_r       <= 1'b0;
      lose_r      <= 1'b0;
`ifdef MATCH_GAME_SCORE_EN
      score_r     <= 8'd0;
`endif
    end else if (start_edge) begin
      st          <= ST_PLAY;
      target_r    <= sym_all;
      secs_ones_r <= 4'd0;
      secs_tens_r <= 4'd0;
      flash_r     <= 1'b0;
      flash_cnt   <= '0;
      win_r       <= 1'b0;
      lose_r      <= 1'b0;
    end else begin
      case (st)
        ST_PLAY: begin
          if (all_match) begin
            st    <= ST_WIN;
            win_r <= 1'b1;
`ifdef MATCH_GAME_SCORE_EN
            if (score_r != 8'hFF) score_r <= score_r + 8'd1;
`endif
          end else if (tick) begin
            secs_ones_r <= ones_nxt;
            secs_tens_r <= tens_nxt;
            if (timeout) begin
              st     <= ST_LOSE;
              lose_r <= 1'b1;
            end
          end
        end
        ST_WIN, ST_LOSE: begin
          if (tick) begin
            if (flash_cnt == FL_LAST) begin
              flash_cnt <= '0;
              flash_r   <= ~flash_r;
            end else begin
              flash_cnt <= flash_cnt + FL_W'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.target    = target_r;
  assign bus.match_vec = match_vec;
  assign bus.secs_ones = secs_ones_r;
  assign bus.secs_tens = secs_tens_r;
  assign bus.state     = st;
  assign bus.win       = win_r;
  assign bus.lose      = lose_r;
  assign bus.flash     = flash_r;
`ifdef MATCH_GAME_SCORE_EN
  assign bus.score     = score_r;
`endif

endmodule
